synth_cfg_writer: RTL and testbench

Transmitter for the synth voice's byte-wide configuration port: accepts a complete voice configuration (48 bits plus per-byte write mask) over a valid/ready handshake and serialises it as one-hot byte-enable strobes plus data on the 8-bit config bus (`cfg_data` to the synth's `uio_in`, `cfg_en` to its `ui_in`). Keeps a shadow of what the synth currently holds, suppresses unchanged bytes and can pace strobes. Sits between the host/sequencer logic and the synth core.

---
 rtl/synth_cfg_pkg.sv | 20 ++
 rtl/synth_cfg_writer_lsb_onehot.sv | 13 +
 rtl/synth_cfg_writer.sv | 139 +++++++++++++
 tb/tb_synth_cfg_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_cfg_pkg.sv
// rtl/synth_cfg_pkg.sv - shared synth voice configuration constants and FSM state type
package synth_cfg_pkg;

   localparam int NUM_CFG_BYTES = 6;
   localparam logic [8*NUM_CFG_BYTES-1:0] SYNTH_CFG_RESET = 48'h0838_0638_0638;

   // Each period field is 16 bits wide starting at these byte indices
   localparam int SAW_PERIOD_BYTE  = 0;
   localparam int OSC_PERIOD_BYTE  = 2;
   localparam int DAMP_PERIOD_BYTE = 4;
   localparam int OCTAVE_LSB       = 9;
   localparam int OCTAVE_MSB       = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } cfg_state_t;

endpackage

// File: rtl/synth_cfg_writer_lsb_onehot.sv
// rtl/synth_cfg_writer_lsb_onehot.sv - isolates the lowest set bit of a vector
module lsb_onehot #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [WIDTH-1:0] o_onehot,
   output logic             o_any
);

   assign o_onehot = i_vec & ((~i_vec) + WIDTH'(1));
   assign o_any    = |i_vec;

endmodule

// File: rtl/synth_cfg_writer.sv
// rtl/synth_cfg_writer.sv - serialises voice configuration onto the synth byte-strobe bus
module synth_cfg_writer
   import synth_cfg_pkg::*;
#(
   parameter int                     NUM_BYTES      = NUM_CFG_BYTES,
   parameter int                     GAP_CYCLES     = 0,
   parameter bit                     SKIP_UNCHANGED = 1'b1,
   parameter logic [8*NUM_BYTES-1:0] RESET_CFG      = SYNTH_CFG_RESET
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [8*NUM_BYTES-1:0]   in_cfg,
   input  logic [NUM_BYTES-1:0]     in_mask,
   input  logic                     resync,
   output logic [7:0]               cfg_data,
   output logic [7:0]               cfg_en,
   output logic                     busy,
   output logic [8*NUM_BYTES-1:0]   shadow
);

   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   cfg_state_t             r_state;
   logic [NUM_BYTES-1:0]   r_pending;
   logic [8*NUM_BYTES-1:0] r_buf;
   logic [3:0]             r_gap_cnt;
   logic [7:0]             r_cfg_en;
   logic [7:0]             r_cfg_data;
   logic [8*NUM_BYTES-1:0] r_shadow;

   cfg_state_t             w_state_nxt;
   logic [NUM_BYTES-1:0]   w_pend_nxt;
   logic [8*NUM_BYTES-1:0] w_buf_nxt;
   logic [3:0]             w_gap_nxt;
   logic [7:0]             w_en_nxt;
   logic [7:0]             w_data_nxt;
   logic [8*NUM_BYTES-1:0] w_shadow_nxt;

   logic [NUM_BYTES-1:0]   w_diff;
   logic [NUM_BYTES-1:0]   w_src_pend;
   logic [8*NUM_BYTES-1:0] w_src_buf;
   logic [NUM_BYTES-1:0]   w_pick;
   logic [NUM_BYTES-1:0]   w_rest;
   logic                   w_any;

   // Issue source: a fresh request or resync in IDLE, the latched buffer in SEND
   always_comb begin
      w_diff     = '0;
      w_src_buf  = r_buf;
      w_src_pend = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         w_diff[i] = (in_cfg[8*i +: 8] != r_shadow[8*i +: 8]);
      end
      if (r_state == IDLE) begin
         if (resync) begin
            w_src_buf  = r_shadow;
            w_src_pend = '1;
         end else if (in_valid) begin
            w_src_buf  = in_cfg;
            w_src_pend = in_mask & (SKIP_UNCHANGED ? w_diff : '1);
         end
      end else if (r_state == SEND) begin
         w_src_pend = r_pending;
      end
   end

   lsb_onehot #(
      .WIDTH (NUM_BYTES)
   ) u_pick (
      .i_vec    (w_src_pend),
      .o_onehot (w_pick),
      .o_any    (w_any)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_pend_nxt   = r_pending;
      w_buf_nxt    = r_buf;
      w_gap_nxt    = r_gap_cnt;
      w_en_nxt     = '0;
      w_data_nxt   = r_cfg_data;
      w_shadow_nxt = r_shadow;
      w_rest       = w_src_pend & ~w_pick;
      if (w_any) begin
         w_pend_nxt = w_rest;
         w_buf_nxt  = w_src_buf;
         w_en_nxt   = 8'(w_pick);
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_pick[i]) begin
               w_data_nxt              = w_src_buf[8*i +: 8];
               w_shadow_nxt[8*i +: 8]  = w_src_buf[8*i +: 8];
            end
         end
         if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_gap_nxt   = GAP_LOAD;
         end else if (|w_rest) begin
            w_state_nxt = SEND;
         end else begin
            w_state_nxt = IDLE;
         end
      end else if (r_state == GAP) begin
         if (r_gap_cnt == 4'd0) begin
            w_state_nxt = (|r_pending) ? SEND : IDLE;
         end else begin
            w_gap_nxt = r_gap_cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_buf      <= '0;
         r_gap_cnt  <= '0;
         r_cfg_en   <= '0;
         r_cfg_data <= '0;
         r_shadow   <= RESET_CFG;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pend_nxt;
         r_buf      <= w_buf_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_cfg_en   <= w_en_nxt;
         r_cfg_data <= w_data_nxt;
         r_shadow   <= w_shadow_nxt;
      end
   end

   assign in_ready = (r_state == IDLE) && !resync;
   assign busy     = (r_state != IDLE);
   assign cfg_en   = r_cfg_en;
   assign cfg_data = r_cfg_data;
   assign shadow   = r_shadow;

endmodule

// File: tb/tb_synth_cfg_writer.sv
// tb/tb_synth_cfg_writer.sv - scoreboard bench for synth_cfg_writer (instances with gap 0 and gap 2)
module tb_synth_cfg_writer;

   localparam logic [47:0] RST_CFG = 48'h0838_0638_0638;

   typedef struct {
      logic [7:0] en;
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v   [2];
   logic        rs  [2];
   logic        rdy [2];
   logic        bz  [2];
   logic [47:0] cfg [2];
   logic [47:0] sh  [2];
   logic [5:0]  msk [2];
   logic [7:0]  cd  [2];
   logic [7:0]  ce  [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   last_strobe [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   synth_cfg_writer #(.GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(v[0]), .in_ready(rdy[0]), .in_cfg(cfg[0]),
      .in_mask(msk[0]), .resync(rs[0]), .cfg_data(cd[0]), .cfg_en(ce[0]), .busy(bz[0]),
      .shadow(sh[0])
   );

   synth_cfg_writer #(.GAP_CYCLES(2)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(v[1]), .in_ready(rdy[1]), .in_cfg(cfg[1]),
      .in_mask(msk[1]), .resync(rs[1]), .cfg_data(cd[1]), .cfg_en(ce[1]), .busy(bz[1]),
      .shadow(sh[1])
   );

   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   task automatic push(input int d, input logic [7:0] en, input logic [7:0] data, input int gap);
      exp_t e;
      e.en = en;
      e.data = data;
      e.gap = gap;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic send(input int d, input logic [47:0] c, input logic [5:0] m);
      int n = 0;
      @(negedge clk);
      v[d] = 1'b1;
      cfg[d] = c;
      msk[d] = m;
      while (!rdy[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         $display("FAIL accept_timeout inst%0d", d);
      end
      @(posedge clk);
      #1;
      v[d] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL drain_timeout left0=%0d left1=%0d exp=0", q0.size(), q1.size());
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every visible strobe must match the head of its instance's queue
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ce[d] != 8'h00) begin
            exp_t e;
            int   sz;
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
               n_checks++;
               $display("FAIL unexpected_strobe inst%0d cfg_en=%02h cfg_data=%02h", d, ce[d], cd[d]);
            end else begin
               if (d == 0) e = q0.pop_front();
               else e = q1.pop_front();
               check($sformatf("strobe_en_inst%0d", d), 48'(ce[d]), 48'(e.en));
               check($sformatf("strobe_data_inst%0d", d), 48'(cd[d]), 48'(e.data));
               if (e.gap != 0)
                  check($sformatf("strobe_spacing_inst%0d", d), 48'(cyc - last_strobe[d]), 48'(e.gap));
            end
            last_strobe[d] = cyc;
         end
      end
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         v[d] = 1'b0;
         rs[d] = 1'b0;
         cfg[d] = '0;
         msk[d] = '0;
         last_strobe[d] = 0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_cfg_en", 48'(ce[0]), 48'h0);
      check("reset_cfg_data", 48'(cd[0]), 48'h0);
      check("reset_busy", 48'(bz[0]), 48'h0);
      check("reset_ready", 48'(rdy[0]), 48'h1);
      check("reset_shadow", sh[0], RST_CFG);

      // Unchanged config: nothing goes on the bus
      send(0, RST_CFG, 6'h3F);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("nochange_ready", 48'(rdy[0]), 48'h1);
         check("nochange_busy", 48'(bz[0]), 48'h0);
      end

      // Full six-byte update, consecutive strobes
      push(0, 8'h01, 8'hAB, 0);
      push(0, 8'h02, 8'h89, 1);
      push(0, 8'h04, 8'h67, 1);
      push(0, 8'h08, 8'h45, 1);
      push(0, 8'h10, 8'h23, 1);
      push(0, 8'h20, 8'h01, 1);
      send(0, 48'h0123_4567_89AB, 6'h3F);
      drain();
      check("full_shadow", sh[0], 48'h0123_4567_89AB);
      check("full_busy_after", 48'(bz[0]), 48'h0);

      // Gap instance: masked bytes 0 and 2, byte 1 changed but masked off
      push(1, 8'h01, 8'h11, 0);
      push(1, 8'h04, 8'h22, 3);
      push(1, 8'h20, 8'h55, 3);
      send(1, 48'h0838_0622_FF11, 6'h05);
      send(1, 48'h5538_0622_FF11, 6'h20);
      drain();
      check("gap_shadow", sh[1], 48'h5538_0622_0611);

      // Resync wins over a simultaneous request, which is then held
      @(negedge clk);
      rs[0] = 1'b1;
      v[0] = 1'b1;
      cfg[0] = 48'h0123_4567_89AC;
      msk[0] = 6'h3F;
      #1;
      check("resync_ready_low", 48'(rdy[0]), 48'h0);
      push(0, 8'h01, 8'hAB, 0);
      push(0, 8'h02, 8'h89, 1);
      push(0, 8'h04, 8'h67, 1);
      push(0, 8'h08, 8'h45, 1);
      push(0, 8'h10, 8'h23, 1);
      push(0, 8'h20, 8'h01, 1);
      push(0, 8'h01, 8'hAC, 1);
      @(posedge clk);
      #1;
      rs[0] = 1'b0;
      @(negedge clk);
      check("resync_held_ready", 48'(rdy[0]), 48'h0);
      check("resync_busy", 48'(bz[0]), 48'h1);
      begin
         int n = 0;
         while (!rdy[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("resync_accept_timeout", 48'(n < 100), 48'h1);
      end
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      drain();
      check("resync_shadow", sh[0], 48'h0123_4567_89AC);

      // Reset during the third strobe
      push(0, 8'h01, 8'hA6, 0);
      push(0, 8'h02, 8'hA5, 1);
      push(0, 8'h04, 8'hA4, 1);
      send(0, 48'hA1A2_A3A4_A5A6, 6'h3F);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_cfg_en", 48'(ce[0]), 48'h0);
      check("midreset_shadow", sh[0], RST_CFG);
      check("midreset_ready", 48'(rdy[0]), 48'h1);
      check("midreset_busy", 48'(bz[0]), 48'h0);
      drain();

      // Back-to-back single-byte updates with no dead cycle
      push(0, 8'h02, 8'h11, 0);
      push(0, 8'h02, 8'h12, 1);
      push(0, 8'h02, 8'h13, 1);
      send(0, 48'h0838_0638_1138, 6'h3F);
      send(0, 48'h0838_0638_1238, 6'h3F);
      send(0, 48'h0838_0638_1338, 6'h3F);
      drain();
      check("b2b_shadow", sh[0], 48'h0838_0638_1338);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
